majority_voter_seq: RTL and testbench
=====================================

MAJORITY_VOTER_SEQ -- requirements
Module: majority_voter_seq

Interface
REQ-001 Parameter NUM_INPUTS, default 5, number of voter inputs; legal range 1..32.
REQ-002 Parameter THRESHOLD, default 0, minimum ones count for a 1 vote; 0 selects strict majority floor(NUM_INPUTS/2)+1; legal range 0..NUM_INPUTS.
REQ-003 Parameter PERSIST, default 3, consecutive disagreeing samples required to flip the filtered output; legal range 1..15.
REQ-004 Port clk, input, 1, sole clock, all state updates on the rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, input_vector is a sample this cycle.
REQ-007 Port input_vector, input, NUM_INPUTS, voter inputs.
REQ-008 Port out_valid, output, 1, single-cycle strobe: outputs carry a new result.
REQ-009 Port count_out, output, CW = $clog2(NUM_INPUTS+1), number of ones in the sample.
REQ-010 Port raw_majority, output, 1, unfiltered vote: count_out >= effective threshold.
REQ-011 Port majority_output, output, 1, persistence-filtered vote.
REQ-012 Port dissent_cnt, output, 16, non-unanimous sample count (only with MAJ_DISSENT_CNT_EN).

Function
REQ-013 Stage 1 SHALL register input_vector and in_valid, capturing input_vector only when in_valid=1.
REQ-014 Stage 2 SHALL register the stage-1 popcount into count_out and the threshold compare into raw_majority when stage-1 valid=1, otherwise hold both.
REQ-015 out_valid SHALL assert exactly 2 cycles after in_valid is sampled high, for 1 cycle per sample; back-to-back in_valid SHALL give back-to-back out_valid with no bubbles.
REQ-016 Popcount SHALL be an exact unsigned sum in CW bits with no overflow at all-ones (count = NUM_INPUTS).
REQ-017 Filter: a PERSIST-range counter pcnt SHALL increment on each valid stage-1 vote differing from majority_output and clear on each valid vote equal to it.
REQ-018 When a differing vote would make pcnt reach PERSIST, majority_output SHALL toggle in that same stage-2 update and pcnt SHALL clear.
REQ-019 Cycles with no valid stage-1 sample SHALL hold pcnt and majority_output unchanged.
REQ-020 With PERSIST=1, majority_output SHALL equal raw_majority on every out_valid.
REQ-021 THRESHOLD > NUM_INPUTS SHALL be rejected at elaboration with a fatal error; THRESHOLD=NUM_INPUTS gives unanimity voting.

Reset
REQ-022 On rst=1 at a rising edge, out_valid, count_out, raw_majority, majority_output, pcnt, the stage-1 valid flag and dissent_cnt SHALL all become 0.
REQ-023 Reset SHALL take priority over in_valid in the same cycle, and samples in flight SHALL be discarded with no out_valid for them.
REQ-024 The first in_valid after rst deasserts SHALL produce out_valid 2 cycles later.

Configuration
REQ-025 With macro MAJ_DISSENT_CNT_EN defined, dissent_cnt SHALL increment on each out_valid whose count_out is neither 0 nor NUM_INPUTS, saturating at 16'hFFFF.
REQ-026 Without MAJ_DISSENT_CNT_EN, the dissent_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NUM_INPUTS=5, THRESHOLD=0, PERSIST=3 unless stated)
REQ-027 Reset release, single in_valid with 5'b00111 -> out_valid 2 cycles later, count_out=3, raw_majority=1, majority_output=0, pcnt=1.
REQ-028 Three consecutive valid 5'b11100 samples from reset -> majority_output rises on the 3rd out_valid only; a following 5'b00011 gives raw_majority=0, majority_output=1.
REQ-029 Valid sequence 11111, 11111, 00000, 11111 from reset -> majority_output stays 0 (counter cleared by the 00000 vote).
REQ-030 Stream 00000, 00001, 00011, 00111, 01111, 11111 back-to-back -> six consecutive out_valid, count_out 0,1,2,3,4,5, raw_majority 0,0,0,1,1,1; with MAJ_DISSENT_CNT_EN, dissent_cnt=4.
REQ-031 rst pulse asserted 1 cycle after in_valid -> no out_valid for that sample, all outputs 0.
REQ-032 NUM_INPUTS=6, THRESHOLD=0 (threshold 4), PERSIST=1 -> 6'b000111 gives count_out=3, raw_majority=0; 6'b001111 gives raw_majority=1 and majority_output=1 on the same out_valid.

Source files
------------

// File: rtl/majority_voter_seq.sv
// Two-stage majority voter with persistence-filtered output; out_valid 2 cycles after in_valid, no backpressure.
// Optional saturating dissent counter when MAJ_DISSENT_CNT_EN is defined.
module majority_voter_seq #(
  parameter int NUM_INPUTS = 5,
  parameter int THRESHOLD  = 0,
  parameter int PERSIST    = 3,
  localparam int CW        = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NUM_INPUTS-1:0] input_vector,
  output logic                  out_valid,
  output logic [CW-1:0]         count_out,
  output logic                  raw_majority,
  output logic                  majority_output
`ifdef MAJ_DISSENT_CNT_EN
  ,
  output logic [15:0]           dissent_cnt
`endif
);

  localparam int            EFF_THR   = (THRESHOLD == 0) ? (NUM_INPUTS / 2 + 1) : THRESHOLD;
  localparam logic [CW-1:0] THR_C     = CW'(EFF_THR);
  localparam logic [CW-1:0] ALL_C     = CW'(NUM_INPUTS);
  localparam logic [3:0]    PERSIST_C = 4'(PERSIST);

  if (NUM_INPUTS < 1 || NUM_INPUTS > 32) begin : g_bad_num_inputs
    $fatal(1, "majority_voter_seq: NUM_INPUTS must be 1..32");
  end
  if (THRESHOLD < 0 || THRESHOLD > NUM_INPUTS) begin : g_bad_threshold
    $fatal(1, "majority_voter_seq: THRESHOLD must be 0..NUM_INPUTS");
  end
  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $fatal(1, "majority_voter_seq: PERSIST must be 1..15");
  end

  logic                  s1_vld_q;
  logic [NUM_INPUTS-1:0] s1_vec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_vec_q <= '0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) s1_vec_q <= input_vector;
    end
  end

  logic [CW-1:0] pop;
  logic          vote;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_INPUTS; i++) pop = pop + CW'(s1_vec_q[i]);
  end

  assign vote = (pop >= THR_C);

  logic          out_vld_q, out_vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_q, raw_d;
  logic          maj_q, maj_d;
  logic [3:0]    pcnt_q, pcnt_d;

  // pcnt counts consecutive votes disagreeing with the filtered output.
  always_comb begin
    out_vld_d = s1_vld_q;
    cnt_d     = cnt_q;
    raw_d     = raw_q;
    maj_d     = maj_q;
    pcnt_d    = pcnt_q;
    if (s1_vld_q) begin
      cnt_d = pop;
      raw_d = vote;
      if (vote == maj_q) begin
        pcnt_d = '0;
      end else if (pcnt_q + 4'd1 == PERSIST_C) begin
        maj_d  = ~maj_q;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
      raw_q     <= 1'b0;
      maj_q     <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      cnt_q     <= cnt_d;
      raw_q     <= raw_d;
      maj_q     <= maj_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign out_valid       = out_vld_q;
  assign count_out       = cnt_q;
  assign raw_majority    = raw_q;
  assign majority_output = maj_q;

`ifdef MAJ_DISSENT_CNT_EN
  logic [15:0] dis_q, dis_d;

  always_comb begin
    dis_d = dis_q;
    if (s1_vld_q && pop != '0 && pop != ALL_C && dis_q != 16'hFFFF) dis_d = dis_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dis_q <= '0;
    else     dis_q <= dis_d;
  end

  assign dissent_cnt = dis_q;
`endif

endmodule

// File: tb/tb_majority_voter_seq.sv
// Bench for majority_voter_seq: 5-input/PERSIST=3 and 6-input/PERSIST=1 instances checked every cycle
// against a sample-level model, with literal expectations attached to directed samples.
module tb_majority_voter_seq;

  localparam int NA = 5, PA = 3, TA = 3;
  localparam int NB = 6, PB = 1, TB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_iv, b_iv;
  logic [4:0] a_vec;
  logic [5:0] b_vec;
  logic       a_ov, b_ov, a_raw, b_raw, a_maj, b_maj;
  logic [2:0] a_cnt, b_cnt;
`ifdef MAJ_DISSENT_CNT_EN
  logic [15:0] a_dis, b_dis;
`endif

  always #5 clk = ~clk;

  majority_voter_seq #(.NUM_INPUTS(NA), .THRESHOLD(0), .PERSIST(PA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .input_vector(a_vec),
    .out_valid(a_ov), .count_out(a_cnt), .raw_majority(a_raw), .majority_output(a_maj)
`ifdef MAJ_DISSENT_CNT_EN
    , .dissent_cnt(a_dis)
`endif
  );

  majority_voter_seq #(.NUM_INPUTS(NB), .THRESHOLD(0), .PERSIST(PB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .input_vector(b_vec),
    .out_valid(b_ov), .count_out(b_cnt), .raw_majority(b_raw), .majority_output(b_maj)
`ifdef MAJ_DISSENT_CNT_EN
    , .dissent_cnt(b_dis)
`endif
  );

  typedef struct packed {
    int cnt;
    bit raw;
    bit maj;
    int run;
    int dis;
  } mst_t;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   kill_until = -1;
  logic [31:0] a_due[int];
  logic [31:0] b_due[int];
  int   a_lit[int];
  int   b_lit[int];

  // One accepted sample, applied straight from the voting rules.
  function automatic mst_t step(mst_t s, logic [31:0] v, int n, int thr, int p);
    int ones;
    ones = $countones(v & ((32'd1 << n) - 32'd1));
    s.cnt = ones;
    s.raw = (ones >= thr);
    if (s.raw != s.maj) begin
      s.run++;
      if (s.run >= p) begin
        s.maj = ~s.maj;
        s.run = 0;
      end
    end else begin
      s.run = 0;
    end
    if (ones != 0 && ones != n && s.dis < 65535) s.dis++;
    return s;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  initial begin : compare
    mst_t ma, mb;
    bit   ev_a, ev_b;
    int   lv;
    ma = '0;
    mb = '0;
    forever begin
      @(posedge clk);
      cyc++;
      ev_a = 1'b0;
      ev_b = 1'b0;
      if (rst) begin
        ma = '0;
        mb = '0;
        kill_until = cyc + 1;
      end else begin
        ev_a = a_due.exists(cyc) && cyc > kill_until;
        ev_b = b_due.exists(cyc) && cyc > kill_until;
        if (ev_a) ma = step(ma, a_due[cyc], NA, TA, PA);
        if (ev_b) mb = step(mb, b_due[cyc], NB, TB, PB);
      end
      @(negedge clk);
      check("a_out_valid", int'(a_ov), int'(ev_a));
      check("a_count", int'(a_cnt), ma.cnt);
      check("a_raw", int'(a_raw), int'(ma.raw));
      check("a_maj", int'(a_maj), int'(ma.maj));
      check("a_pcnt", int'(dut_a.pcnt_q), ma.run);
      check("b_out_valid", int'(b_ov), int'(ev_b));
      check("b_count", int'(b_cnt), mb.cnt);
      check("b_raw", int'(b_raw), int'(mb.raw));
      check("b_maj", int'(b_maj), int'(mb.maj));
`ifdef MAJ_DISSENT_CNT_EN
      check("a_dissent", int'(a_dis), ma.dis);
      check("b_dissent", int'(b_dis), mb.dis);
`endif
      if (ev_a && a_lit.exists(cyc)) begin
        lv = a_lit[cyc];
        check("a_lit_count", int'(a_cnt), lv / 4);
        check("a_lit_raw", int'(a_raw), (lv / 2) % 2);
        check("a_lit_maj", int'(a_maj), lv % 2);
        check("a_lit_vs_model", lv, ma.cnt * 4 + int'(ma.raw) * 2 + int'(ma.maj));
      end
      if (ev_b && b_lit.exists(cyc)) begin
        lv = b_lit[cyc];
        check("b_lit_count", int'(b_cnt), lv / 4);
        check("b_lit_raw", int'(b_raw), (lv / 2) % 2);
        check("b_lit_maj", int'(b_maj), lv % 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_a(input logic [4:0] v, input bit lit, input int c, input bit r, input bit m);
    a_vec = v;
    a_iv  = 1'b1;
    a_due[cyc + 2] = {27'd0, v};
    if (lit) a_lit[cyc + 2] = c * 4 + int'(r) * 2 + int'(m);
    tick();
    a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [5:0] v, input int c, input bit r, input bit m);
    b_vec = v;
    b_iv  = 1'b1;
    b_due[cyc + 2] = {26'd0, v};
    b_lit[cyc + 2] = c * 4 + int'(r) * 2 + int'(m);
    tick();
    b_iv = 1'b0;
  endtask

  initial begin : stim
    rst   = 1'b1;
    a_iv  = 1'b0;
    b_iv  = 1'b0;
    a_vec = '0;
    b_vec = '0;
    idle(2);
    rst = 1'b0;
    idle(2);

    send_a(5'b00111, 1, 3, 1, 0);
    idle(4);

    do_reset();
    send_a(5'b11100, 1, 3, 1, 0);
    send_a(5'b11100, 1, 3, 1, 0);
    send_a(5'b11100, 1, 3, 1, 1);
    send_a(5'b00011, 1, 2, 0, 1);
    idle(4);

    do_reset();
    send_a(5'b11111, 1, 5, 1, 0);
    send_a(5'b11111, 1, 5, 1, 0);
    send_a(5'b00000, 1, 0, 0, 0);
    send_a(5'b11111, 1, 5, 1, 0);
    idle(4);

    do_reset();
    send_a(5'b00000, 1, 0, 0, 0);
    send_a(5'b00001, 1, 1, 0, 0);
    send_a(5'b00011, 1, 2, 0, 0);
    send_a(5'b00111, 1, 3, 1, 0);
    send_a(5'b01111, 1, 4, 1, 0);
    send_a(5'b11111, 1, 5, 1, 1);
    idle(4);

    // Gapped samples: outputs hold between strobes.
    send_a(5'b00000, 1, 0, 0, 1);
    idle(3);
    send_a(5'b00001, 1, 1, 0, 1);
    idle(2);
    send_a(5'b10000, 1, 1, 0, 0);
    idle(4);

    // Reset one cycle after a sample: that sample never emerges.
    send_a(5'b11111, 0, 0, 0, 0);
    do_reset();
    idle(4);

    // Reset and in_valid together: reset wins.
    rst = 1'b1;
    send_a(5'b11111, 0, 0, 0, 0);
    rst = 1'b0;
    idle(3);
    send_a(5'b11011, 1, 4, 1, 0);
    idle(4);

    do_reset();
    send_b(6'b000111, 3, 0, 0);
    send_b(6'b001111, 4, 1, 1);
    send_b(6'b111111, 6, 1, 1);
    send_b(6'b000000, 0, 0, 0);
    idle(2);
    send_b(6'b110110, 4, 1, 1);
    idle(4);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) send_a(5'($urandom_range(0, 31)), 0, 0, 0, 0);
      else idle(1);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
